// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and the default datapath width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int unsigned ALU_W = 8;

endpackage

// File: rtl/serial_sub_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_sub_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
);

    logic             start;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic             Bi;
    logic [WIDTH-1:0] Dout;
    logic             Bo;
    logic             ovf;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, Ain, Bin, Bi,
        input  Dout, Bo, ovf, zero, busy, done
    );

    modport slave (
        input  start, Ain, Bin, Bi,
        output Dout, Bo, ovf, zero, busy, done
    );

endinterface

// File: rtl/serial_sub_bitsub.sv
// One-bit full subtractor cell: D = A - B - Bin, with borrow out.
module bitsub (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell reused each cycle.
module serial_sub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W
) (
    input logic          clk,
    input logic          rst_n,
    serial_sub_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state;
    state_e           state_nxt;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [WIDTH-1:0] dout;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             sign_a;
    logic             sign_b;
    logic             bo;
    logic             ovf;
    logic             zero;
    logic             d;
    logic             br_nxt;
    logic             last;
    logic             accept;

    bitsub u_cell (
        .A    (reg_a[0]),
        .B    (reg_b[0]),
        .Bin  (br),
        .D    (d),
        .Bout (br_nxt)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                // back-to-back start skips IDLE entirely
                accept    = bus.start;
                state_nxt = bus.start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            reg_a  <= '0;
            reg_b  <= '0;
            dout   <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            bo     <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                reg_a  <= bus.Ain;
                reg_b  <= bus.Bin;
                br     <= bus.Bi;
                cnt    <= '0;
                sign_a <= bus.Ain[WIDTH-1];
                sign_b <= bus.Bin[WIDTH-1];
            end else if (state == RUN) begin
                reg_a <= reg_a >> 1;
                reg_b <= reg_b >> 1;
                br    <= br_nxt;
                dout  <= {d, dout[WIDTH-1:1]};
                cnt   <= cnt + CNT_W'(1);
                // flags are taken from the final bit, which becomes the MSB of dout
                if (last) begin
                    bo   <= br_nxt;
                    zero <= ({d, dout[WIDTH-1:1]} == '0);
                    ovf  <= (sign_a != sign_b) && (d != sign_a);
                end
            end
        end
    end

    assign bus.Dout = dout;
    assign bus.Bo   = bo;
    assign bus.ovf  = ovf;
    assign bus.zero = zero;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases plus random operands against an arithmetic model.
module tb_serial_sub;
    import alu_pkg::*;

    localparam int unsigned W = ALU_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ovf;
    logic         exp_zero;

    serial_sub_if #(.WIDTH(W)) bus ();

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request and compute the expected result from plain unsigned arithmetic.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W:0] diff;
        bus.start = 1'b1;
        bus.Ain   = a;
        bus.Bin   = b;
        bus.Bi    = bi;
        diff      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        exp_d     = diff[W-1:0];
        exp_bo    = diff[W];
        exp_zero  = (exp_d == '0);
        exp_ovf   = (a[W-1] != b[W-1]) && (exp_d[W-1] != a[W-1]);
    endtask

    task automatic wait_done(input string tag, input bit hold, input bit scramble);
        int n        = 0;
        int busy_cnt = 0;
        for (int i = 1; i <= 4 * W + 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n = i;
                break;
            end
            if (bus.busy) busy_cnt++;
            if (!hold) bus.start = 1'b0;
            if (scramble) begin
                bus.Ain = W'($urandom);
                bus.Bin = W'($urandom);
                bus.Bi  = 1'($urandom);
            end
        end
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    endtask

    task automatic check_res(input string tag);
        chk({tag, "_dout"}, 32'(bus.Dout), 32'(exp_d));
        chk({tag, "_bo"},   32'(bus.Bo),   32'(exp_bo));
        chk({tag, "_ovf"},  32'(bus.ovf),  32'(exp_ovf));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt;
        logic [W+3:0] held;

        bus.start = 1'b0;
        bus.Ain   = '0;
        bus.Bin   = '0;
        bus.Bi    = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_dout",  32'(bus.Dout), 32'h0);
        chk("reset_flags", 32'({bus.Bo, bus.ovf, bus.zero, bus.busy, bus.done}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed single operations with an idle cycle between them
        start_op(8'h50, 8'h20, 1'b0); wait_done("t50m20", 0, 0); check_res("t50m20");
        chk("t50m20_const", 32'(bus.Dout), 32'h30);
        @(negedge clk);
        start_op(8'h20, 8'h50, 1'b0); wait_done("t20m50", 0, 0); check_res("t20m50");
        @(negedge clk);
        start_op(8'h80, 8'h01, 1'b0); wait_done("t80m01", 0, 0); check_res("t80m01");
        chk("t80m01_ovf_const", 32'(bus.ovf), 32'h1);
        @(negedge clk);
        start_op(8'h37, 8'h37, 1'b0); wait_done("t37m37", 0, 0); check_res("t37m37");
        @(negedge clk);
        start_op(8'h00, 8'h00, 1'b1); wait_done("t00bi", 0, 0); check_res("t00bi");
        chk("t00bi_const", 32'(bus.Dout), 32'hFF);
        @(negedge clk);

        // start held with operands changing during RUN, then back-to-back request
        start_op(8'h10, 8'h01, 1'b0); wait_done("hold", 1, 1); check_res("hold");
        start_op(8'h05, 8'h03, 1'b0); wait_done("b2b", 0, 0); check_res("b2b");
        @(negedge clk);

        // reset during the 4th RUN cycle aborts the operation
        start_op(8'hAB, 8'h12, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_dout", 32'(bus.Dout), 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(done_cnt), 32'h0);
        start_op(8'h09, 8'h04, 1'b0); wait_done("after_rst", 0, 0); check_res("after_rst");

        // results hold through idle while inputs wander
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.Ain = W'($urandom);
            bus.Bin = W'($urandom);
            bus.Bi  = 1'($urandom);
            held = {bus.Dout, bus.Bo, bus.ovf, bus.zero, bus.done};
            chk($sformatf("hold_idle%0d", i), 32'(held), 32'({exp_d, exp_bo, exp_ovf, exp_zero, 1'b0}));
        end

        // random operands, alternating idle-gap and back-to-back issue
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            wait_done($sformatf("rnd%0d", i), 0, i % 2);
            check_res($sformatf("rnd%0d", i));
            if (i % 2 == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial WIDTH-bit subtractor computing Dout = Ain - Bin - Bi, LSB first, one bit per clock.
- Inverse-direction companion to the team's ripple-carry adder: subtraction instead of addition, borrow instead of carry.
- Time-multiplexed instead of a parallel ripple chain, with a start/busy/done handshake so an ALU sequencer can drive it.
- Uses one full-subtractor cell and a registered borrow.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 2 or more.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when the block is idle or done.
- Ain  in  WIDTH  minuend; captured on the accepted start.
- Bin  in  WIDTH  subtrahend; captured on the accepted start.
- Bi  in  1  borrow in; captured on the accepted start.
- Dout  out  WIDTH  difference; valid while done=1 and held until the next accepted start.
- Bo  out  1  borrow out (1 when Ain < Bin + Bi, unsigned).
- ovf  out  1  signed (two's-complement) overflow.
- zero  out  1  Dout == 0.
- busy  out  1  1 while a subtraction is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Reset: on a clk edge with rst_n=0, all state goes to IDLE. Dout, Bo, ovf, zero, busy, done, the counter, the shift registers and the borrow register all become 0. Reset during RUN aborts the operation; no done pulse is produced.
- States:
  - IDLE: busy=0, done=0. start=1 loads regA=Ain, regB=Bin, br=Bi, cnt=0, and latches signA=Ain[WIDTH-1] and signB=Bin[WIDTH-1]. Next state is RUN.
  - RUN: busy=1. Each edge computes d = regA[0]^regB[0]^br and br_next = (~regA[0]&regB[0]) | (~(regA[0]^regB[0])&br). Then:
    - regA and regB shift right.
    - d shifts into Dout at the MSB while Dout shifts right.
    - cnt increments.
    - When cnt == WIDTH-1 on that edge, next state is DONE.
    - start is ignored in RUN; Ain, Bin and Bi may change freely.
  - DONE: busy=0, done=1 for exactly this cycle. Dout holds the final difference. Bo = final borrow. zero = (Dout == 0). ovf = (signA != signB) && (Dout[WIDTH-1] != signA).
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back; no dead cycle) and the next state is RUN.
    - Otherwise the next state is IDLE.
- Result holding: Dout, Bo, ovf and zero are registered and hold their DONE values through IDLE until the next accepted start. On that start they may begin changing in the following cycles and are undefined for the consumer until the next done.
- Latency: start is sampled at edge k; WIDTH RUN edges follow (k+1 … k+WIDTH); done=1 in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Arithmetic is modulo 2^WIDTH. Bi=1 with Ain == Bin gives all-ones and Bo=1.
- Simultaneous events: rst_n=0 takes priority over start in all states.

Decomposition:
- Shared package alu_pkg holds:
  - The state enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - The default width constant ALU_W=8, shared with the adder.
- One sub-module, bitsub: a combinational full subtractor with ports A, B, Bin, D, Bout. It mirrors the adder's one-bit cell and is instantiated once inside serial_sub.
- The counter, shift registers and FSM stay in serial_sub.

Test Plan:
- Ain=0x50, Bin=0x20, Bi=0, start for 1 cycle -> done exactly 9 cycles after start was sampled; Dout=0x30, Bo=0, ovf=0, zero=0; busy=1 for 8 cycles.
- Ain=0x20, Bin=0x50, Bi=0 -> Dout=0xD0, Bo=1, ovf=0. Then Ain=0x80, Bin=0x01 -> Dout=0x7F, Bo=0, ovf=1.
- Ain=0x37, Bin=0x37, Bi=0 -> Dout=0x00, zero=1, Bo=0. Then Ain=0x00, Bin=0x00, Bi=1 -> Dout=0xFF, Bo=1, zero=0, ovf=0.
- start held high with changing Ain/Bin during RUN (Ain=0x10, Bin=0x01 captured) -> result 0x0F unaffected by later changes.
  - start=1 in the DONE cycle with new operands 0x05-0x03 -> busy in the next cycle, no IDLE gap; next Dout=0x02.
- rst_n=0 for one edge at the 4th RUN cycle -> busy=0, Dout=0, no done pulse.
  - A fresh start afterwards (0x09-0x04) -> Dout=0x05 with normal latency.
- Results hold: after done, idle 20 cycles with random inputs and start=0 -> Dout, Bo, ovf and zero remain stable; done stays 0.
